muldiv_stall_sched: RTL
=======================

Name: muldiv_stall_sched

Overview:
- Pipeline stall/flush scheduler for the 5-stage MIPS core.
- Shares the single multi-cycle MULT/DIV unit with the instruction stream by sequencing it through a small FSM. While the unit runs, the front end is frozen.
- Merges the hazard unit's load-use stall request and the ID-stage branch redirect into one prioritised set of PC / IF-ID / ID-EX enables and flushes.

Parameters:
- MUL_CYCLES, 4, cycles the MULT unit needs after start (must be ≥1).
- DIV_CYCLES, 32, cycles the DIV unit needs after start (must be ≥1).
- CNT_W, 6, cycle-counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_stall  input  1  load-use stall request from the hazard detector (combinational, current cycle).
- md_req  input  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- md_is_div  input  1  qualifies md_req: 1 = divide, 0 = multiply.
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- pc_en  output  1  PC register write enable.
- if_id_en  output  1  IF/ID register write enable.
- if_id_flush  output  1  clear IF/ID to NOP on next edge.
- id_ex_flush  output  1  insert bubble into ID/EX on next edge.
- md_start  output  1  one-cycle start pulse to the MULT/DIV unit.
- md_busy  output  1  unit in operation (state RUN).
- md_done  output  1  one-cycle pulse: HI/LO valid, unit about to release.

Behaviour:
- The reset is asynchronous active-low. While rst_n=0, the outputs are forced to:
  - pc_en=1, if_id_en=1
  - if_id_flush=0, id_ex_flush=0
  - md_start=0, md_busy=0, md_done=0
- Reset also sets state=IDLE and cnt=0.
- FSM states are IDLE, RUN and WB.
- IDLE:
  - If md_req=1 and load_stall=0: assert md_start=1 this cycle, load cnt=(md_is_div ? DIV_CYCLES : MUL_CYCLES)-1, and go to RUN.
  - md_req with load_stall=1: load_stall wins. No start; md_req is re-evaluated each cycle.
- RUN:
  - md_busy=1.
  - cnt decrements each cycle.
  - When cnt==0, go to WB; otherwise stay in RUN.
  - Inputs md_req and branch_taken are ignored.
- WB:
  - md_done=1 for exactly one cycle, then go to IDLE.
- Freeze rule: when (md_start | state≠IDLE), drive pc_en=0, if_id_en=0, id_ex_flush=1 and if_id_flush=0.
  - The MD instruction is held in ID and advances on the first IDLE cycle after WB.
  - In that IDLE cycle md_req for the same instruction is still high. It must not restart the unit, so a one-bit flag `served` is set in WB and cleared when if_id_en=1 in IDLE. md_start requires served=0.
- Load stall, when not frozen: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0.
- Branch, when neither frozen nor load-stalled and branch_taken=1: if_id_flush=1, pc_en=1, if_id_en=1.
  - If stalled, the branch stays in ID and is honoured on the cycle the stall clears.
- Priority: freeze > load_stall > branch_taken > normal.
- Normal: pc_en=1, if_id_en=1, both flushes 0.
- Latency: with N cycles selected, md_start occurs in cycle T, RUN covers T+1..T+N, WB is at T+N+1, and IDLE resumes at T+N+2.
  - Total frozen cycles (pc_en=0) = N+2.
- Boundary conditions:
  - N=1: RUN lasts one cycle.
  - Back-to-back MD instructions: the second starts on the cycle it reaches ID, once served is clear.
  - Reset asserted mid-RUN: the FSM aborts immediately, and the unit's partial result is discarded by the core reset.
- All outputs except md_start, md_busy and md_done are combinational from state and inputs. md_busy and md_done decode the registered state.

Optional Feature:
- STALL_PERF_EN:
  - When defined, adds output port stall_cycles (32-bit). It increments on each rising edge where pc_en=0, saturates at 32'hFFFFFFFF, and resets to 0.
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with md_req=1 and load_stall=1 -> pc_en=1, md_start=0, md_busy=0 throughout; state IDLE after release.
- MULT (MUL_CYCLES=4): md_req=1, md_is_div=0 at cycle 10 -> md_start@10, md_busy@11..14, md_done@15, pc_en=0 @10..15, pc_en=1 @16, no second md_start@16.
- DIV (DIV_CYCLES=32): start @20 -> md_done@53, exactly 34 cycles with pc_en=0; branch_taken=1 @30 -> if_id_flush stays 0.
- load_stall=1 and md_req=1 together @5, load_stall=0 @6 -> md_start only @6, id_ex_flush=1 @5..
- branch_taken=1 with load_stall=1 @8, load_stall=0 @9 -> if_id_flush=0 @8, =1 @9.
- rst_n low at cycle 3 of a DIV RUN -> md_busy drops asynchronously; after release the next md_req starts a fresh full DIV_CYCLES run.

Source files
------------

// File: rtl/muldiv_stall_sched_if.sv
// Signals between the ID-stage control and the MULT/DIV stall scheduler.
// master = core/ID side driving requests, slave = scheduler.
interface muldiv_stall_sched_if;
    logic load_stall;
    logic md_req;
    logic md_is_div;
    logic branch_taken;
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic md_start;
    logic md_busy;
    logic md_done;

    modport master (
        output load_stall, md_req, md_is_div, branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, md_start, md_busy, md_done
    );
    modport slave (
        input  load_stall, md_req, md_is_div, branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, md_start, md_busy, md_done
    );
endinterface

// File: rtl/muldiv_stall_sched.sv
// Stall/flush scheduler sharing the MULT/DIV unit; freezes the front end for N+2 cycles per op.
// Enables/flushes are combinational; optional STALL_PERF_EN adds a saturating stall_cycles counter.
module muldiv_stall_sched #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    muldiv_stall_sched_if.slave  bus
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             served;
    logic             start;
    logic             frozen;

    // served blocks the still-present md_req of an instruction already executed
    assign start  = rst_n && (state == IDLE) && bus.md_req && !bus.load_stall && !served;
    assign frozen = start || (state != IDLE);

    always_comb begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (rst_n) begin
            if (frozen || bus.load_stall) begin
                bus.pc_en       = 1'b0;
                bus.if_id_en    = 1'b0;
                bus.id_ex_flush = 1'b1;
            end else if (bus.branch_taken) begin
                bus.if_id_flush = 1'b1;
            end
        end
    end

    assign bus.md_start = start;
    assign bus.md_busy  = (state == RUN);
    assign bus.md_done  = (state == WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            served <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= bus.md_is_div ? DIV_LD : MUL_LD;
                        state <= RUN;
                    end
                    if (bus.if_id_en) served <= 1'b0;
                end
                RUN: begin
                    if (cnt == '0) state <= WB;
                    else           cnt   <= cnt - 1'b1;
                end
                WB: begin
                    served <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (!bus.pc_en && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
